// File: rtl/calc1_req_sched.sv
// rtl/calc1_req_sched.sv - four-port round-robin request scheduler in front of a shared calc1 ALU
// Optional watchdog on the ALU wait: define CALC1_SCHED_TIMEOUT_EN
module calc1_req_sched #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic              alu_valid,
  output logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic              alu_done,
  input  logic [1:0]        alu_resp,
  input  logic [DATA_W-1:0] alu_data
);

  typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND, P_RJ} port_state_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} sched_state_e;

  logic [3:0]        cmd_in  [4];
  logic [DATA_W-1:0] data_in [4];

  port_state_e       pst_q [4];
  port_state_e       pst_d [4];
  logic [3:0]        cmd_q [4];
  logic [3:0]        cmd_d [4];
  logic [DATA_W-1:0] op1_q [4];
  logic [DATA_W-1:0] op1_d [4];
  logic [DATA_W-1:0] op2_q [4];
  logic [DATA_W-1:0] op2_d [4];

  logic [3:0]        cand;
  logic [3:0]        rel;

  sched_state_e      sst_q, sst_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rsp_q, rsp_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [1:0]        pick;
  logic              found;
  logic              tmo_fire;

  logic [1:0]        resp_w [4];
  logic [DATA_W-1:0] dat_w  [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // Per-port request capture: command+op1, then op2, then hold until answered or rejected.
  always_comb begin
    cand = '0;
    rel  = '0;
    for (int i = 0; i < 4; i++) begin
      pst_d[i] = pst_q[i];
      cmd_d[i] = cmd_q[i];
      op1_d[i] = op1_q[i];
      op2_d[i] = op2_q[i];
      rel[i]   = (sst_q == S_RESP) && (gnt_q == 2'(i));
      unique case (pst_q[i])
        P_IDLE: begin
          if (cmd_in[i] != 4'd0) begin
            cmd_d[i] = cmd_in[i];
            op1_d[i] = data_in[i];
            pst_d[i] = P_OP2;
          end
        end
        P_OP2: begin
          op2_d[i] = data_in[i];
          pst_d[i] = cmd_valid(cmd_q[i]) ? P_PEND : P_RJ;
        end
        P_PEND: begin
          if (rel[i]) pst_d[i] = P_IDLE;
        end
        P_RJ: pst_d[i] = P_IDLE;
        default: pst_d[i] = P_IDLE;
      endcase
      // A valid request is grantable on the edge that moves it into P_PEND, so an
      // uncontended request issues two cycles after its command cycle.
      cand[i] = (pst_q[i] == P_PEND) || ((pst_q[i] == P_OP2) && cmd_valid(cmd_q[i]));
    end
  end

  // Port state registers.
  always_ff @(posedge c_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        pst_q[i] <= P_IDLE;
        cmd_q[i] <= '0;
        op1_q[i] <= '0;
        op2_q[i] <= '0;
      end else begin
        pst_q[i] <= pst_d[i];
        cmd_q[i] <= cmd_d[i];
        op1_q[i] <= op1_d[i];
        op2_q[i] <= op2_d[i];
      end
    end
  end

  // Round-robin pick and scheduler next state: grant, issue, wait for ALU, respond.
  always_comb begin
    sst_d  = sst_q;
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    rsp_d  = rsp_q;
    rdat_d = rdat_q;
    pick   = ptr_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = 2'(ptr_q + 2'(k));
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    unique case (sst_q)
      S_IDLE: begin
        if (found) begin
          gnt_d = pick;
          ptr_d = pick;
          sst_d = S_ISSUE;
        end
      end
      S_ISSUE: sst_d = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          rsp_d  = alu_resp;
          rdat_d = alu_data;
          sst_d  = S_RESP;
        end else if (tmo_fire) begin
          rsp_d  = 2'd2;
          rdat_d = '0;
          sst_d  = S_RESP;
        end
      end
      S_RESP: sst_d = S_IDLE;
      default: sst_d = S_IDLE;
    endcase
  end

  // Scheduler registers; pointer resets to port 4 so port 1 wins first.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      sst_q  <= S_IDLE;
      ptr_q  <= 2'd3;
      gnt_q  <= 2'd0;
      rsp_q  <= 2'd0;
      rdat_q <= '0;
    end else begin
      sst_q  <= sst_d;
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      rsp_q  <= rsp_d;
      rdat_q <= rdat_d;
    end
  end

`ifdef CALC1_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // Watchdog: counts cycles in S_WAIT, restarted by every issue.
  always_ff @(posedge c_clk) begin
    if (reset || (sst_q == S_ISSUE)) begin
      tmo_q <= '0;
    end else if (sst_q == S_WAIT) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_fire = (sst_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  // No watchdog: S_WAIT holds until the ALU answers. TIMEOUT stays referenced so
  // both builds share one parameter list.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
  assign tmo_fire = 1'b0;
`endif

  assign alu_valid = (sst_q == S_ISSUE);
  assign alu_cmd   = alu_valid ? cmd_q[gnt_q] : '0;
  assign alu_op1   = alu_valid ? op1_q[gnt_q] : '0;
  assign alu_op2   = alu_valid ? op2_q[gnt_q] : '0;

  // Response routing: reject from the port itself, or the ALU result to the granted port.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_w[i] = 2'd0;
      dat_w[i]  = '0;
      if (pst_q[i] == P_RJ) begin
        resp_w[i] = 2'd2;
      end else if (rel[i]) begin
        resp_w[i] = rsp_q;
        dat_w[i]  = (rsp_q == 2'd1) ? rdat_q : '0;
      end
    end
  end

  assign out_resp1 = resp_w[0];
  assign out_resp2 = resp_w[1];
  assign out_resp3 = resp_w[2];
  assign out_resp4 = resp_w[3];
  assign out_data1 = dat_w[0];
  assign out_data2 = dat_w[1];
  assign out_data3 = dat_w[2];
  assign out_data4 = dat_w[3];

endmodule

// File: tb/tb_calc1_req_sched.sv
// tb/tb_calc1_req_sched.sv - directed table-driven bench for calc1_req_sched
module tb_calc1_req_sched;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cmd_in   [4];
  logic [DW-1:0] data_in  [4];
  logic [1:0]    out_resp [4];
  logic [DW-1:0] out_data [4];
  logic          alu_valid;
  logic [3:0]    alu_cmd;
  logic [DW-1:0] alu_op1, alu_op2;
  logic          alu_done;
  logic [1:0]    alu_resp;
  logic [DW-1:0] alu_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc1_req_sched #(.DATA_W(DW), .TIMEOUT(8)) dut (
    .c_clk(clk), .reset(rst),
    .req1_cmd_in(cmd_in[0]), .req2_cmd_in(cmd_in[1]),
    .req3_cmd_in(cmd_in[2]), .req4_cmd_in(cmd_in[3]),
    .req1_data_in(data_in[0]), .req2_data_in(data_in[1]),
    .req3_data_in(data_in[2]), .req4_data_in(data_in[3]),
    .out_resp1(out_resp[0]), .out_resp2(out_resp[1]),
    .out_resp3(out_resp[2]), .out_resp4(out_resp[3]),
    .out_data1(out_data[0]), .out_data2(out_data[1]),
    .out_data3(out_data[2]), .out_data4(out_data[3]),
    .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_done(alu_done), .alu_resp(alu_resp), .alu_data(alu_data)
  );

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    bit          issue;
    logic [1:0]  alu_rsp;
    logic [31:0] alu_res;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s resp%0d", tag, p + 1), 32'(out_resp[p]), 32'd0);
      chk($sformatf("%s data%0d", tag, p + 1), out_data[p], 32'd0);
    end
    chk($sformatf("%s alu_valid", tag), 32'(alu_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    @(negedge clk);
    cmd_in[v.port]  = v.cmd;
    data_in[v.port] = v.op1;
    @(negedge clk);
    cmd_in[v.port]  = 4'd0;
    data_in[v.port] = v.op2;
    @(negedge clk);
    data_in[v.port] = '0;
    if (v.issue) begin
      chk($sformatf("v%0d alu_valid T+2", n), 32'(alu_valid), 32'd1);
      chk($sformatf("v%0d alu_cmd", n), 32'(alu_cmd), 32'(v.cmd));
      chk($sformatf("v%0d alu_op1", n), alu_op1, v.op1);
      chk($sformatf("v%0d alu_op2", n), alu_op2, v.op2);
      @(negedge clk);
      chk($sformatf("v%0d alu_valid one cycle", n), 32'(alu_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      alu_done = 1'b1;
      alu_resp = v.alu_rsp;
      alu_data = v.alu_res;
      @(negedge clk);
      alu_done = 1'b0;
      alu_resp = 2'd0;
      alu_data = '0;
    end else begin
      chk($sformatf("v%0d no issue", n), 32'(alu_valid), 32'd0);
    end
    chk($sformatf("v%0d resp", n), 32'(out_resp[v.port]), 32'(v.exp_rsp));
    chk($sformatf("v%0d data", n), out_data[v.port], v.exp_dat);
    for (int q = 0; q < 4; q++) begin
      if (q != v.port) chk($sformatf("v%0d other resp%0d", n, q + 1), 32'(out_resp[q]), 32'd0);
    end
    @(negedge clk);
    chk($sformatf("v%0d resp one cycle", n), 32'(out_resp[v.port]), 32'd0);
    chk($sformatf("v%0d idle alu_valid", n), 32'(alu_valid), 32'd0);
  endtask

  task automatic serve(input int exp_port, input string tag);
    int n;
    n = 0;
    while (alu_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " issued"}, 32'(alu_valid), 32'd1);
    chk({tag, " grant op1"}, alu_op1, 32'(exp_port + 1));
    @(negedge clk);
    alu_done = 1'b1;
    alu_resp = 2'd1;
    alu_data = 32'h100 + 32'(exp_port);
    @(negedge clk);
    alu_done = 1'b0;
    alu_resp = 2'd0;
    alu_data = '0;
    chk({tag, " resp"}, 32'(out_resp[exp_port]), 32'd1);
    chk({tag, " data"}, out_data[exp_port], 32'h100 + 32'(exp_port));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    //          port cmd   op1           op2           issue rsp  alu_res       exp  exp_dat
    vecs[0] = '{0, 4'd1,  32'h00000001, 32'h1FFFFFFF, 1'b1, 2'd1, 32'h20000000, 2'd1, 32'h20000000};
    vecs[1] = '{2, 4'd3,  32'h00000011, 32'h00000022, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    vecs[2] = '{1, 4'd1,  32'hFFFFFFFF, 32'h00000001, 1'b1, 2'd2, 32'hDEADBEEF, 2'd2, 32'h0};
    vecs[3] = '{1, 4'd2,  32'h00000005, 32'h00000003, 1'b1, 2'd1, 32'h00000002, 2'd1, 32'h00000002};
    vecs[4] = '{3, 4'd5,  32'h00000001, 32'h00000004, 1'b1, 2'd1, 32'h00000010, 2'd1, 32'h00000010};
    vecs[5] = '{0, 4'd6,  32'h00000080, 32'h00000003, 1'b1, 2'd1, 32'h00000010, 2'd1, 32'h00000010};
    vecs[6] = '{1, 4'd15, 32'h00000001, 32'h00000001, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    vecs[7] = '{3, 4'd4,  32'h00000009, 32'h00000009, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0};

    rst = 1'b1;
    alu_done = 1'b0;
    alu_resp = 2'd0;
    alu_data = '0;
    for (int p = 0; p < 4; p++) begin
      cmd_in[p]  = 4'd0;
      data_in[p] = '0;
    end
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset alu_cmd", 32'(alu_cmd), 32'd0);
    chk("reset alu_op1", alu_op1, 32'd0);
    chk("reset alu_op2", alu_op2, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four ports request together: grants 1,2,3,4 from the reset pointer.
    for (int p = 0; p < 4; p++) begin
      cmd_in[p]  = 4'd1;
      data_in[p] = 32'(p + 1);
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      cmd_in[p]  = 4'd0;
      data_in[p] = 32'd10;
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) data_in[p] = '0;
    serve(0, "rr1");
    serve(1, "rr2");
    serve(2, "rr3");
    serve(3, "rr4");

    // Ports 4 and 2 together with pointer at 4: port 2 first.
    cmd_in[3] = 4'd1; data_in[3] = 32'd4;
    cmd_in[1] = 4'd1; data_in[1] = 32'd2;
    @(negedge clk);
    cmd_in[3] = 4'd0; data_in[3] = 32'd1;
    cmd_in[1] = 4'd0; data_in[1] = 32'd1;
    @(negedge clk);
    data_in[3] = '0;
    data_in[1] = '0;
    serve(1, "rr_b2");
    serve(3, "rr_b4");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while waiting on the ALU; the late alu_done must produce nothing.
    cmd_in[0] = 4'd1; data_in[0] = 32'd7;
    @(negedge clk);
    cmd_in[0] = 4'd0; data_in[0] = 32'd8;
    @(negedge clk);
    data_in[0] = '0;
    chk("rst issue", 32'(alu_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    alu_done = 1'b1;
    alu_resp = 2'd1;
    alu_data = 32'd15;
    @(negedge clk);
    alu_done = 1'b0;
    alu_resp = 2'd0;
    alu_data = '0;
    for (int k = 0; k < 4; k++) begin
      chk_quiet($sformatf("post-reset c%0d", k));
      @(negedge clk);
    end
    run_vec(vecs[0], 100);

`ifdef CALC1_SCHED_TIMEOUT_EN
    cmd_in[0] = 4'd1; data_in[0] = 32'd3;
    @(negedge clk);
    cmd_in[0] = 4'd0; data_in[0] = 32'd4;
    @(negedge clk);
    data_in[0] = '0;
    chk("tmo issue", 32'(alu_valid), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("tmo wait %0d", k), 32'(out_resp[0]), 32'd0);
    end
    @(negedge clk);
    chk("tmo resp", 32'(out_resp[0]), 32'd2);
    chk("tmo data", out_data[0], 32'd0);
    @(negedge clk);
    alu_done = 1'b1;
    alu_resp = 2'd1;
    alu_data = 32'd99;
    @(negedge clk);
    alu_done = 1'b0;
    alu_resp = 2'd0;
    alu_data = '0;
    chk_quiet("tmo late done a");
    @(negedge clk);
    chk_quiet("tmo late done b");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
